// File: rtl/aes_pkg.sv
// Shared constants for the AES round-0 input loader: default geometry,
// the loader state encoding and the FIPS-197 reference vectors.
package aes_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int BLOCK_LENGTH    = 128;
  localparam int KEY_LENGTH      = 128;
  localparam int WORDS_PER_BLOCK = BLOCK_LENGTH / WORD_WIDTH;
  localparam int WORDS_PER_KEY   = KEY_LENGTH / WORD_WIDTH;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } loader_state_t;

  localparam logic [127:0] FIPS197_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS197_PT  = 128'h00112233445566778899aabbccddeeff;

endpackage

// File: rtl/aes_word_packer.sv
// Shift-in register with a word counter; the first word shifted in ends up in
// the MSBs once WORDS words have arrived. done strobes on the last word.
module aes_word_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_WIDTH-1:0]       word,
  input  logic                        shift_en,
  output logic [WORDS*WORD_WIDTH-1:0] assembled,
  output logic                        empty,
  output logic                        done
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int W  = WORDS * WORD_WIDTH;

  logic [W-1:0]  shreg;
  logic [CW-1:0] count;

  // assembled is the register contents as they will be after this word
  generate
    if (WORDS == 1) begin : g_single
      assign assembled = word;
    end else begin : g_multi
      assign assembled = {shreg[W-WORD_WIDTH-1:0], word};
    end
  endgenerate

  assign empty = (count == '0);
  assign done  = shift_en && (count == CW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
    end else if (shift_en) begin
      shreg <= assembled;
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_input_loader.sv
// Round-0 feeder: assembles the cipher key and 128-bit plaintext blocks from a
// valid/ready word stream. Optional macro: LOADER_DOUBLE_BUF_EN (no ISSUE bubble).
module aes_input_loader #(
  parameter int BLOCK_LENGTH = aes_pkg::BLOCK_LENGTH,
  parameter int KEY_LENGTH   = aes_pkg::KEY_LENGTH,
  parameter int WORD_WIDTH   = aes_pkg::WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_WIDTH-1:0]   in_word,
  input  logic                    in_valid,
  input  logic                    in_sel_key,
  output logic                    in_ready,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic [KEY_LENGTH-1:0]   KEY,
  output logic                    key_valid,
  output logic                    next_round_enable
);

  import aes_pkg::*;

  localparam int N_DATA = BLOCK_LENGTH / WORD_WIDTH;
  localparam int N_KEY  = KEY_LENGTH / WORD_WIDTH;

  loader_state_t state;

  logic                    data_xfer, key_xfer;
  logic                    data_empty, data_done;
  logic                    key_empty, key_done;
  logic [BLOCK_LENGTH-1:0] data_asm;
  logic [KEY_LENGTH-1:0]   key_asm;

  // Key and data never interleave: a key needs an empty block, data needs a whole key
  always_comb begin
    in_ready  = !rst && (state == FILL) &&
                (in_sel_key ? data_empty : (key_valid && key_empty));
    data_xfer = in_valid && in_ready && !in_sel_key;
    key_xfer  = in_valid && in_ready && in_sel_key;
  end

  aes_word_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (N_DATA)
  ) u_data_packer (
    .clk       (clk),
    .rst       (rst),
    .word      (in_word),
    .shift_en  (data_xfer),
    .assembled (data_asm),
    .empty     (data_empty),
    .done      (data_done)
  );

  aes_word_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (N_KEY)
  ) u_key_packer (
    .clk       (clk),
    .rst       (rst),
    .word      (in_word),
    .shift_en  (key_xfer),
    .assembled (key_asm),
    .empty     (key_empty),
    .done      (key_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= FILL;
      OUT               <= '0;
      KEY               <= '0;
      key_valid         <= 1'b0;
      next_round_enable <= 1'b0;
    end else begin
      next_round_enable <= 1'b0;

      if (key_xfer) begin
        if (key_done) begin
          KEY       <= key_asm;
          key_valid <= 1'b1;
        end else if (key_empty) begin
          key_valid <= 1'b0;
        end
      end

      if (data_done) begin
        OUT               <= data_asm;
        next_round_enable <= 1'b1;
      end

`ifdef LOADER_DOUBLE_BUF_EN
      state <= FILL;
`else
      case (state)
        FILL:  if (data_done) state <= ISSUE;
        ISSUE: state <= FILL;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_aes_input_loader.sv
// Self-checking bench for aes_input_loader: FIPS-197 table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_aes_input_loader;
  import aes_pkg::*;

  logic         clk;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_sel_key;
  logic         in_ready;
  logic [127:0] OUT;
  logic [127:0] KEY;
  logic         key_valid;
  logic         next_round_enable;

  int n_checks = 0;
  int n_fail   = 0;

  aes_input_loader #(
    .BLOCK_LENGTH (128),
    .KEY_LENGTH   (128),
    .WORD_WIDTH   (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_word           (in_word),
    .in_valid          (in_valid),
    .in_sel_key        (in_sel_key),
    .in_ready          (in_ready),
    .OUT               (OUT),
    .KEY               (KEY),
    .key_valid         (key_valid),
    .next_round_enable (next_round_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // Reference model: words collected in queues, outputs rebuilt from them
  logic [31:0]  kq[$];
  logic [31:0]  dq[$];
  logic [127:0] m_key, m_out;
  logic         m_kv, m_pulse, m_busy;

  function automatic logic model_ready(input logic s);
    if (m_busy) return 1'b0;
    if (s) return (dq.size() == 0);
    return m_kv && (kq.size() == 0);
  endfunction

  task automatic model_update(input logic r, input logic xfer, input logic s, input logic [31:0] w);
    logic [127:0] acc;
    if (r) begin
      kq.delete(); dq.delete();
      m_key = '0; m_out = '0; m_kv = 1'b0; m_pulse = 1'b0; m_busy = 1'b0;
      return;
    end
    m_pulse = 1'b0;
    m_busy  = 1'b0;
    if (xfer && s) begin
      kq.push_back(w);
      if (kq.size() == WORDS_PER_KEY) begin
        acc = '0;
        foreach (kq[i]) acc = (acc << 32) | 128'(kq[i]);
        m_key = acc;
        m_kv  = 1'b1;
        kq.delete();
      end else begin
        m_kv = 1'b0;
      end
    end
    if (xfer && !s) begin
      dq.push_back(w);
      if (dq.size() == WORDS_PER_BLOCK) begin
        acc = '0;
        foreach (dq[i]) acc = (acc << 32) | 128'(dq[i]);
        m_out   = acc;
        m_pulse = 1'b1;
`ifndef LOADER_DOUBLE_BUF_EN
        m_busy  = 1'b1;
`endif
        dq.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check in_ready, clock, check registered outputs
  task automatic step(input logic r, input logic v, input logic s, input logic [31:0] w,
                      output logic rdy_o, output logic pls_o);
    logic er;
    rst = r; in_valid = v; in_sel_key = s; in_word = w;
    #1;
    er    = r ? 1'b0 : model_ready(s);
    rdy_o = in_ready;
    check("in_ready", 256'(in_ready), 256'(er));
    @(posedge clk);
    #1;
    model_update(r, v && er, s, w);
    pls_o = next_round_enable;
    check("next_round_enable", 256'(next_round_enable), 256'(m_pulse));
    check("OUT", 256'(OUT), 256'(m_out));
    check("KEY", 256'(KEY), 256'(m_key));
    check("key_valid", 256'(key_valid), 256'(m_kv));
  endtask

  typedef struct {
    logic        v;
    logic        s;
    logic [31:0] w;
    logic        rdy;
    logic        pulse;
  } vec_t;

  vec_t         tbl[9];
  logic         rdy, pls;
  logic [127:0] kv_vec, pt_vec, key2;
  int           pulse_at[$];
  int           exp_at[3];

  task automatic load_key(input logic [127:0] k);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, k[127-32*i -: 32], rdy, pls);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel_key = 1'b0; in_word = '0;
    model_update(1'b1, 1'b0, 1'b0, '0);
    kv_vec = FIPS197_KEY;
    pt_vec = FIPS197_PT;
    key2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    // Reset state
    step(1'b1, 1'b1, 1'b1, 32'hdeadbeef, rdy, pls);
    check("reset in_ready", 256'(rdy), 256'(0));
    check("reset OUT", 256'(OUT), 256'(0));
    check("reset KEY", 256'(KEY), 256'(0));
    check("reset key_valid", 256'(key_valid), 256'(0));

    // Data before key is refused
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h11110000 + i, rdy, pls);
      check("nokey in_ready", 256'(rdy), 256'(0));
      check("nokey pulse", 256'(pls), 256'(0));
      check("nokey OUT", 256'(OUT), 256'(0));
    end

    // FIPS-197 vector table
    for (int unsigned i = 0; i < 4; i++) begin
      tbl[i]   = '{1'b1, 1'b1, kv_vec[127-32*i -: 32], 1'b1, 1'b0};
      tbl[i+4] = '{1'b1, 1'b0, pt_vec[127-32*i -: 32], 1'b1, (i == 3)};
    end
`ifdef LOADER_DOUBLE_BUF_EN
    tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
`else
    tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
`endif
    for (int unsigned i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].v, tbl[i].s, tbl[i].w, rdy, pls);
      check($sformatf("tbl[%0d] in_ready", i), 256'(rdy), 256'(tbl[i].rdy));
      check($sformatf("tbl[%0d] pulse", i), 256'(pls), 256'(tbl[i].pulse));
    end
    check("fips KEY", 256'(KEY), 256'(128'h000102030405060708090a0b0c0d0e0f));
    check("fips key_valid", 256'(key_valid), 256'(1));
    check("fips OUT", 256'(OUT), 256'(128'h00112233445566778899aabbccddeeff));

    // Key refused mid-block; accepted after the block issues
    step(1'b0, 1'b1, 1'b0, 32'ha0a0a0a0, rdy, pls);
    step(1'b0, 1'b1, 1'b0, 32'hb1b1b1b1, rdy, pls);
    step(1'b0, 1'b1, 1'b1, 32'hcccccccc, rdy, pls);
    check("midblock key in_ready", 256'(rdy), 256'(0));
    step(1'b0, 1'b1, 1'b0, 32'hc2c2c2c2, rdy, pls);
    step(1'b0, 1'b1, 1'b0, 32'hd3d3d3d3, rdy, pls);
    check("midblock issue pulse", 256'(pls), 256'(1));
    check("midblock OUT", 256'(OUT), 256'(128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3));
    step(1'b0, 1'b0, 1'b1, 32'h0, rdy, pls);
    check("pulse width", 256'(pls), 256'(0));

    // Key reload
    step(1'b0, 1'b1, 1'b1, key2[127:96], rdy, pls);
    check("reload accept", 256'(rdy), 256'(1));
    check("reload key_valid drop", 256'(key_valid), 256'(0));
    check("reload KEY held", 256'(KEY), 256'(128'h000102030405060708090a0b0c0d0e0f));
    step(1'b0, 1'b1, 1'b0, 32'h12345678, rdy, pls);
    check("reload data refused", 256'(rdy), 256'(0));
    step(1'b0, 1'b1, 1'b1, key2[95:64], rdy, pls);
    step(1'b0, 1'b1, 1'b1, key2[63:32], rdy, pls);
    check("reload KEY still old", 256'(KEY), 256'(128'h000102030405060708090a0b0c0d0e0f));
    step(1'b0, 1'b1, 1'b1, key2[31:0], rdy, pls);
    check("reload KEY new", 256'(KEY), 256'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    check("reload key_valid", 256'(key_valid), 256'(1));

    // Continuous valid over three blocks
`ifdef LOADER_DOUBLE_BUF_EN
    exp_at = '{4, 8, 12};
`else
    exp_at = '{4, 9, 14};
`endif
    for (int c = 1; c <= 15; c++) begin
      step(1'b0, 1'b1, 1'b0, $urandom, rdy, pls);
      if (pls) pulse_at.push_back(c);
    end
    check("stream pulse count", 256'(pulse_at.size()), 256'(3));
    for (int unsigned i = 0; i < 3; i++)
      check($sformatf("stream pulse %0d cycle", i),
            256'((pulse_at.size() > i) ? pulse_at[i] : -1), 256'(exp_at[i]));

    // Reset mid-fill
    step(1'b1, 1'b0, 1'b0, 32'h0, rdy, pls);
    load_key(kv_vec);
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'hee000000 + i, rdy, pls);
    step(1'b1, 1'b1, 1'b0, 32'hee000003, rdy, pls);
    check("midfill rst pulse", 256'(pls), 256'(0));
    check("midfill rst OUT", 256'(OUT), 256'(0));
    check("midfill rst KEY", 256'(KEY), 256'(0));
    check("midfill rst key_valid", 256'(key_valid), 256'(0));
    load_key(kv_vec);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, pt_vec[127-32*i -: 32], rdy, pls);
    check("post-rst pulse", 256'(pls), 256'(1));
    check("post-rst OUT", 256'(OUT), 256'(128'h00112233445566778899aabbccddeeff));

    // Randomized traffic against the model
    for (int unsigned n = 0; n < 2000; n++) begin
      step(($urandom_range(199) == 0), ($urandom_range(9) < 7),
           ($urandom_range(9) < 3), $urandom, rdy, pls);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
